// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl: digit-serial sequencer driving an external single-digit BCD adder
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] op_a,
  input  logic [4*DIGITS-1:0] op_b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] result,
  output logic                cout,
  output logic                invalid,
  output logic [3:0]          add_a,
  output logic [3:0]          add_b,
  output logic                add_cin,
  input  logic [3:0]          add_sum,
  input  logic                add_cout
);
  localparam int W  = 4 * DIGITS;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  typedef enum logic {IDLE, ADD} state_t;
  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, result_q, result_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d, cout_q, cout_d, invalid_q, invalid_d, done_q, done_d;
  logic            bad, last;
  logic [IW+1:0]   base;
  assign base    = {idx_q, 2'b00};
  assign last    = idx_q == IW'(DIGITS - 1);
  assign busy    = state_q == ADD;
  assign add_a   = busy ? a_q[base +: 4] : 4'd0;
  assign add_b   = busy ? b_q[base +: 4] : 4'd0;
  assign add_cin = busy & carry_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign invalid = invalid_q;
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++)
      bad = bad | (op_a[4*i +: 4] > 4'd9) | (op_b[4*i +: 4] > 4'd9);
  end
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    invalid_d = invalid_q;
    done_d    = 1'b0;
    if (state_q == IDLE && start) begin
      a_d       = op_a;
      b_d       = op_b;
      result_d  = '0;
      idx_d     = '0;
      carry_d   = cin;
      invalid_d = bad;
      state_d   = ADD;
    end else if (state_q == ADD) begin
      result_d[base +: 4] = add_sum;
      carry_d = add_cout;
      idx_d   = last ? '0 : idx_q + 1'b1;
      cout_d  = last ? add_cout : cout_q;
      done_d  = last;
      state_d = last ? IDLE : ADD;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      idx_q     <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      invalid_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      idx_q     <= idx_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      invalid_q <= invalid_d;
      done_q    <= done_d;
    end
  end
endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl: scoreboard bench with a decimal reference model
module tb_bcd_serial_add_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, cin = 1'b0;
  logic [15:0] op_a = '0, op_b = '0, result;
  logic        busy, done, cout, invalid, add_cin, add_cout;
  logic [3:0]  add_a, add_b, add_sum;
  int          n_checks = 0, n_fail = 0;
  typedef struct {logic [15:0] res; logic co; logic inv; logic chk_res;} exp_t;
  exp_t sb[$];
  bcd_serial_add_ctrl #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b), .cin(cin),
    .busy(busy), .done(done), .result(result), .cout(cout), .invalid(invalid),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout)
  );
  always #5 clk = ~clk;
  always_comb begin
    logic [4:0] s;
    s        = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    add_cout = s > 5'd9;
    add_sum  = add_cout ? 4'(s + 5'd6) : s[3:0];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic c);
    exp_t e;
    int ia, ib, t, da, db;
    e.inv = 1'b0;
    ia = 0;
    ib = 0;
    for (int k = 3; k >= 0; k--) begin
      da = int'(a[4*k +: 4]);
      db = int'(b[4*k +: 4]);
      if (da > 9 || db > 9) e.inv = 1'b1;
      ia = ia * 10 + da;
      ib = ib * 10 + db;
    end
    t = ia + ib + int'(c);
    e.co = t >= 10000;
    t = t % 10000;
    e.res = '0;
    for (int k = 0; k < 4; k++) begin
      e.res[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    e.chk_res = !e.inv;
    return e;
  endfunction
  function automatic logic [15:0] rand_bcd(input logic allow_bad);
    logic [15:0] v;
    for (int k = 0; k < 4; k++) v[4*k +: 4] = 4'($urandom_range(0, 9));
    if (allow_bad && $urandom_range(0, 4) == 0) v[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
    return v;
  endfunction
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      chk("done_expected", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        if (e.chk_res) begin
          chk("result", 32'(result), 32'(e.res));
          chk("cout", 32'(cout), 32'(e.co));
        end
        chk("invalid", 32'(invalid), 32'(e.inv));
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic c, input logic spam);
    int n;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    cin   = c;
    sb.push_back(model(a, b, c));
    @(negedge clk);
    start = 1'b0;
    op_a  = rand_bcd(1'b1);
    op_b  = rand_bcd(1'b1);
    cin   = 1'($urandom_range(0, 1));
    n = 0;
    while (!done && n < 20) begin
      if (busy) n++;
      start = spam && (n == 1 || n == 2);
      if (start) begin
        op_a = rand_bcd(1'b0);
        op_b = rand_bcd(1'b0);
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_cycles", 32'(n), 32'd4);
  endtask
  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    op_a  = 16'h1234;
    op_b  = 16'h5678;
    cin   = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_invalid", 32'(invalid), 32'd0);
    chk("rst_add", 32'({add_a, add_b, add_cin}), 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    @(negedge clk);
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0);
    chk("basic_result_const", 32'(result), 32'h6912);
    run_op(16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op(16'h9999, 16'h9999, 1'b1, 1'b0);
    run_op(16'h0000, 16'h0000, 1'b1, 1'b0);
    run_op(16'h00C3, 16'h0004, 1'b0, 1'b0);
    run_op(16'h4321, 16'h1111, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    start = 1'b1;
    op_a  = 16'h5555;
    op_b  = 16'h5555;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_result", 32'(result), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (6) @(negedge clk);
    run_op(16'h0808, 16'h0203, 1'b1, 1'b0);
    for (int i = 0; i < 30; i++) begin
      run_op(rand_bcd(1'b1), rand_bcd(1'b1), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Digit-serial sequencer that adds two DIGITS-wide packed-BCD operands by feeding one digit pair per cycle into the team's existing single-digit BCD adder and collecting its Sum/Cout. It sits directly upstream of that adder, which it instantiates externally through the add_* port group. It owns operand latching, carry chaining, result assembly and a start/busy/done handshake. The adder itself is combinational and is not part of this block.

## Interface
- DIGITS, 4, number of BCD digits per operand (≥1); digit 0 is the least-significant nibble.
- clk  in  1  rising-edge clock; one clock, no other clock domains.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  request; sampled only in IDLE.
- op_a  in  4*DIGITS  packed-BCD operand A.
- op_b  in  4*DIGITS  packed-BCD operand B.
- cin  in  1  initial carry into digit 0.
- busy  out  1  high while an addition is in progress.
- done  out  1  one-cycle pulse; result, cout and invalid are valid.
- result  out  4*DIGITS  packed-BCD sum; held until the next accepted start.
- cout  out  1  carry out of the most-significant digit.
- invalid  out  1  an operand nibble was >9 at start.
- add_a  out  4  digit A to the BCD adder.
- add_b  out  4  digit B to the BCD adder.
- add_cin  out  1  carry to the BCD adder.
- add_sum  in  4  BCD adder Sum, combinational from add_*.
- add_cout  in  1  BCD adder Cout.

## Operation
- FSM states: IDLE, ADD.
- IDLE with start=1 at a clock edge:
  - Latch op_a, op_b into internal registers.
  - carry ← cin; digit index ← 0; result ← 0.
  - invalid ← OR over all 2·DIGITS nibbles of (nibble > 9).
  - Go to ADD.
- ADD:
  - add_a = a_reg[idx], add_b = b_reg[idx], add_cin = carry. All three are driven from registers only, never from the op_* inputs.
  - At each edge: result[idx] ← add_sum; carry ← add_cout; idx ← idx+1.
  - At the edge capturing idx = DIGITS−1: cout ← add_cout, done ← 1, go to IDLE.
- IDLE drives add_a = 0, add_b = 0, add_cin = 0.
- start while busy is ignored. No queuing; the in-flight operation is unaffected.
- Operand changes after the start edge have no effect.
- Invalid digits are still processed. Result is whatever the adder returns, and invalid flags it. invalid holds until the next accepted start.
- The index counter is wide enough for DIGITS and never wraps past DIGITS−1.

## Timing
- Reset (rst_n=0 at an edge):
  - State → IDLE; busy, done, cout, invalid = 0; result = 0; add_* = 0; internal carry/idx = 0.
  - Reset mid-operation aborts the addition. No done pulse is generated for it.
- Let the start edge be E0. Then:
  - busy = 1 from E0 until the edge E_DIGITS, where it returns to 0.
  - Digit k is captured at edge E(k+1).
  - done = 1 for exactly the cycle following edge E_DIGITS. Latency is DIGITS cycles from the start edge.
- result bits for digit k update at E(k+1). Partial results are visible during busy but are defined only once done is asserted.
- A start asserted during the done cycle (state IDLE) is accepted. Back-to-back throughput is one operation per DIGITS+1 cycles.
- Combinational path add_* → adder → add_sum/add_cout must close within one clk period.

## Test plan
- Reset: hold rst_n=0 for 2 edges with start=1 → busy=0, done=0, result=0x0000, cout=0, add_a=add_b=0.
- Basic carry chain (DIGITS=4): op_a=0x1234, op_b=0x5678, cin=0 → after 4 cycles done=1, result=0x6912, cout=0, invalid=0; busy high for exactly 4 cycles.
- Full ripple: op_a=0x9999, op_b=0x0001, cin=0 → result=0x0000, cout=1. Then op_a=0x9999, op_b=0x9999, cin=1 → result=0x9999, cout=1. Also op_a=0x0000, op_b=0x0000, cin=1 → result=0x0001, cout=0.
- Invalid digit: op_a=0x00C3, op_b=0x0004, cin=0 → invalid=1 at done; done still pulses after 4 cycles.
- Handshake:
  - start pulsed at E1 and E2 during busy, with different operands → ignored; first result unchanged, exactly one done.
  - start in the done cycle → new operation accepted immediately.
- Reset mid-operation: rst_n=0 at E2 of an addition → busy=0 next cycle, result=0, no done. A following start produces a correct result.
